// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding and oversampling constants
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_t;

  localparam int OVERSAMPLE = 16;
  localparam int MID_TICK   = 7;

endpackage

// File: rtl/uart_sync2.sv
// rtl/uart_sync2.sv - two-flop synchroniser with configurable reset value
module uart_sync2
  import uart_pkg::*;
#(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_os.sv
// rtl/uart_rx_os.sv - 16x oversampling UART receiver with one-entry holding register
// Optional parity stage enabled by defining UART_RX_PARITY_EN.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_tick,
  input  logic       rx,
  input  logic       rd_ack,
  output logic [7:0] dout,
  output logic       rx_valid,
  output logic       rx_done_tick,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun_err
);

  // Stop lengths above one bit need a fifth tick-counter bit.
  localparam int SW = (SB_TICK > OVERSAMPLE) ? 5 : 4;
  localparam logic [SW-1:0] S_MID  = SW'(MID_TICK);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_END  = SW'(SB_TICK - 1);
  localparam logic [2:0]    N_LAST = 3'(DBIT - 1);
`ifdef UART_RX_PARITY_EN
  localparam uart_state_t AFTER_DATA = PARITY;
`else
  localparam uart_state_t AFTER_DATA = STOP;
`endif

  logic          rx_s;
  uart_state_t   state_q, state_d;
  logic [SW-1:0] s_q, s_d;
  logic [2:0]    n_q, n_d;
  logic [7:0]    b_q, b_d;
  logic          stop_ok_q, stop_ok_d;
  logic          frame_done;
  logic          perr_calc;

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

`ifdef UART_RX_PARITY_EN
  logic       par_q, par_d;
  logic [7:0] data_aligned;
  assign data_aligned = b_q >> (8 - DBIT);
  assign perr_calc    = par_q != ((^data_aligned) ^ PARITY_ODD);
`else
  assign perr_calc = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      s_q       <= '0;
      n_q       <= '0;
      b_q       <= '0;
      stop_ok_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      n_q       <= n_d;
      b_q       <= b_d;
      stop_ok_q <= stop_ok_d;
`ifdef UART_RX_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    s_d        = s_q;
    n_d        = n_q;
    b_d        = b_q;
    stop_ok_d  = stop_ok_q;
    frame_done = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d      = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          s_d     = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_q == S_MID) begin
            if (!rx_s) begin
              state_d = DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_q == S_LAST) begin
            s_d = '0;
            b_d = {rx_s, b_q[7:1]};
            if (n_q == N_LAST) state_d = AFTER_DATA;
            else               n_d     = n_q + 3'd1;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      PARITY: begin
`ifdef UART_RX_PARITY_EN
        if (s_tick) begin
          if (s_q == S_LAST) begin
            par_d   = rx_s;
            s_d     = '0;
            state_d = STOP;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
`else
        state_d = IDLE;
`endif
      end
      STOP: begin
        if (s_tick) begin
          // With one stop bit the sample and completion share a tick, so use stop_ok_d.
          if (s_q == S_LAST) stop_ok_d = rx_s;
          if (s_q == S_END) begin
            frame_done = 1'b1;
            state_d    = IDLE;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  logic parity_err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout         <= '0;
      rx_valid     <= 1'b0;
      rx_done_tick <= 1'b0;
      frame_err    <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_err  <= 1'b0;
    end else begin
      rx_done_tick <= frame_done;
      if (frame_done && (!rx_valid || rd_ack)) begin
        dout         <= b_q >> (8 - DBIT);
        frame_err    <= !stop_ok_d;
        parity_err_q <= perr_calc;
        rx_valid     <= 1'b1;
        if (rd_ack) overrun_err <= 1'b0;
      end else if (frame_done) begin
        overrun_err <= 1'b1;
      end else if (rd_ack && rx_valid) begin
        rx_valid    <= 1'b0;
        overrun_err <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_os.sv
// tb/tb_uart_rx_os.sv - randomized self-checking bench for uart_rx_os against a frame-level model
module tb_uart_rx_os;

`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int D8 = 8, SB8 = 16, D7 = 7, SB7 = 24;

  logic clk = 1'b0;
  logic reset, s_tick, tx_line, sel7, rd_ack8, rd_ack7;
  logic rx8, rx7;
  logic [7:0] dout8, dout7;
  logic valid8, done8, ferr8, perr8, ovr8;
  logic valid7, done7, ferr7, perr7, ovr7;

  int tick_num = 0;
  int n_checks = 0;
  int n_fail   = 0;
  int cnt_done[2];
  int last_done_tick[2];

  logic [7:0] m_dout[2];
  bit m_valid[2], m_ferr[2], m_perr[2], m_ovr[2];
  int m_done[2];

  assign rx8 = sel7 ? 1'b1 : tx_line;
  assign rx7 = sel7 ? tx_line : 1'b1;

  always #5 clk = ~clk;

  uart_rx_os #(.DBIT(D8), .SB_TICK(SB8)) u_dut8 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .rx(rx8), .rd_ack(rd_ack8),
    .dout(dout8), .rx_valid(valid8), .rx_done_tick(done8),
    .frame_err(ferr8), .parity_err(perr8), .overrun_err(ovr8)
  );

  uart_rx_os #(.DBIT(D7), .SB_TICK(SB7)) u_dut7 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .rx(rx7), .rd_ack(rd_ack7),
    .dout(dout7), .rx_valid(valid7), .rx_done_tick(done7),
    .frame_err(ferr7), .parity_err(perr7), .overrun_err(ovr7)
  );

  // One s_tick every third clk, changed 2ns after the edge.
  initial begin
    s_tick = 1'b0;
    forever begin
      repeat (2) @(posedge clk);
      #2 s_tick = 1'b1;
      tick_num++;
      @(posedge clk);
      #2 s_tick = 1'b0;
    end
  end

  initial begin
    cnt_done[0] = 0; cnt_done[1] = 0;
    last_done_tick[0] = -1; last_done_tick[1] = -1;
    forever begin
      @(negedge clk);
      if (done8 === 1'b1) begin cnt_done[0]++; last_done_tick[0] = tick_num; end
      if (done7 === 1'b1) begin cnt_done[1]++; last_done_tick[1] = tick_num; end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_dout[d] = 8'h00; m_valid[d] = 0; m_ferr[d] = 0; m_perr[d] = 0; m_ovr[d] = 0;
    end
  endtask

  task automatic model_frame(input int d, input logic [7:0] data, input int dbit,
                             input bit ferr, input bit perr, input bit ack);
    logic [7:0] mask;
    mask = 8'((1 << dbit) - 1);
    m_done[d]++;
    if (!m_valid[d] || ack) begin
      m_dout[d]  = data & mask;
      m_valid[d] = 1;
      m_ferr[d]  = ferr;
      m_perr[d]  = perr;
      if (ack) m_ovr[d] = 0;
    end else begin
      m_ovr[d] = 1;
    end
  endtask

  task automatic check_dut(input int d, input string tag);
    if (d == 0) begin
      check({tag, ".dout"}, dout8, m_dout[0]);
      check({tag, ".valid"}, valid8, m_valid[0]);
      check({tag, ".ferr"}, ferr8, m_ferr[0]);
      check({tag, ".perr"}, perr8, m_perr[0]);
      check({tag, ".ovr"}, ovr8, m_ovr[0]);
    end else begin
      check({tag, ".dout"}, dout7, m_dout[1]);
      check({tag, ".valid"}, valid7, m_valid[1]);
      check({tag, ".ferr"}, ferr7, m_ferr[1]);
      check({tag, ".perr"}, perr7, m_perr[1]);
      check({tag, ".ovr"}, ovr7, m_ovr[1]);
    end
    check({tag, ".ndone"}, cnt_done[d], m_done[d]);
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      do @(negedge clk); while (s_tick !== 1'b1);
    end
  endtask

  task automatic send_frame(input bit to7, input logic [7:0] data, input bit par_bit,
                            input bit stop_bit, output int start_tick);
    int dbit, sbt;
    dbit = to7 ? D7 : D8;
    sbt  = to7 ? SB7 : SB8;
    sel7 = to7;
    wait_ticks(1);
    start_tick = tick_num;
    tx_line = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < dbit; i++) begin
      tx_line = data[i];
      wait_ticks(16);
    end
    if (PAR_EN) begin
      tx_line = par_bit;
      wait_ticks(16);
    end
    // Stop level covers the mid-bit sample; the line is idle again before completion.
    tx_line = stop_bit;
    wait_ticks(12);
    tx_line = 1'b1;
    wait_ticks(sbt - 12);
  endtask

  task automatic ack_at(input int d, input int ct);
    int guard = 0;
    while (tick_num != ct && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (tick_num != ct) check("ack_timeout", tick_num, ct);
    if (d == 0) rd_ack8 = 1'b1; else rd_ack7 = 1'b1;
    @(negedge clk);
    rd_ack8 = 1'b0; rd_ack7 = 1'b0;
  endtask

  task automatic pulse_ack(input int d);
    @(negedge clk);
    if (d == 0) rd_ack8 = 1'b1; else rd_ack7 = 1'b1;
    @(negedge clk);
    rd_ack8 = 1'b0; rd_ack7 = 1'b0;
    model_ack(d);
  endtask

  task automatic model_ack(input int d);
    if (m_valid[d]) begin
      m_valid[d] = 0;
      m_ovr[d]   = 0;
    end
  endtask

  task automatic frame(input bit to7, input logic [7:0] data, input bit bad_par,
                       input bit stop_bit, input bit ack_done, input string tag);
    int d, dbit, sbt, lat, st;
    logic [7:0] mask;
    bit pbit, perr;
    d    = to7 ? 1 : 0;
    dbit = to7 ? D7 : D8;
    sbt  = to7 ? SB7 : SB8;
    mask = 8'((1 << dbit) - 1);
    pbit = (^(data & mask)) ^ bad_par;
    perr = PAR_EN && bad_par;
    lat  = 8 + 16 * dbit + (PAR_EN ? 16 : 0) + sbt;
    if (ack_done) begin
      fork
        send_frame(to7, data, pbit, stop_bit, st);
        ack_at(d, tick_num + 1 + lat);
      join
    end else begin
      send_frame(to7, data, pbit, stop_bit, st);
    end
    model_frame(d, data, dbit, !stop_bit, perr, ack_done);
    check({tag, ".done_at"}, last_done_tick[d], st + lat);
    check_dut(d, tag);
  endtask

  initial begin
    logic [7:0] rd;
    int mode;
    bit stp, bp;
    m_done[0] = 0; m_done[1] = 0;
    model_reset();
    reset = 1'b1; tx_line = 1'b1; sel7 = 1'b0; rd_ack8 = 1'b0; rd_ack7 = 1'b0;
    repeat (3) @(negedge clk);
    check_dut(0, "rst8");
    check_dut(1, "rst7");
    check("rst8.done", done8, 1'b0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    frame(1'b0, 8'h55, 1'b0, 1'b1, 1'b0, "f55");
    pulse_ack(0);
    check_dut(0, "f55_ack");

    sel7 = 1'b0;
    wait_ticks(1);
    tx_line = 1'b0;
    wait_ticks(4);
    tx_line = 1'b1;
    wait_ticks(24);
    check_dut(0, "glitch");

    frame(1'b0, 8'hA3, 1'b0, 1'b0, 1'b0, "fa3_stoplow");
    pulse_ack(0);

    frame(1'b0, 8'h11, 1'b0, 1'b1, 1'b0, "ovr_11");
    frame(1'b0, 8'h22, 1'b0, 1'b1, 1'b0, "ovr_22");
    pulse_ack(0);
    check_dut(0, "ovr_ack");
    frame(1'b0, 8'h11, 1'b0, 1'b1, 1'b0, "coin_11");
    frame(1'b0, 8'h22, 1'b0, 1'b1, 1'b1, "coin_22");
    pulse_ack(0);

`ifdef UART_RX_PARITY_EN
    frame(1'b0, 8'h07, 1'b1, 1'b1, 1'b0, "par_bad");
    pulse_ack(0);
    frame(1'b0, 8'h07, 1'b0, 1'b1, 1'b0, "par_good");
    pulse_ack(0);
`endif

    for (int i = 0; i < 10; i++) begin
      rd   = 8'($urandom_range(0, 255));
      stp  = ($urandom_range(0, 3) != 0);
      bp   = PAR_EN ? 1'($urandom_range(0, 1)) : 1'b0;
      mode = $urandom_range(0, 2);
      frame(1'b0, rd, bp, stp, mode == 2, $sformatf("rnd%0d", i));
      if (mode == 1) pulse_ack(0);
    end

    frame(1'b1, 8'h5A, 1'b0, 1'b1, 1'b0, "d7_5a");
    check("d7_5a.bit7", dout7[7], 1'b0);

    // Interrupted frame: start bit then ones, so no new start is seen after reset.
    sel7 = 1'b1;
    wait_ticks(1);
    tx_line = 1'b0;
    wait_ticks(16);
    tx_line = 1'b1;
    wait_ticks(40);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    check_dut(1, "rst_mid7");
    check_dut(0, "rst_mid8");
    check("rst_mid7.done", done7, 1'b0);
    reset = 1'b0;
    wait_ticks(160);
    check_dut(1, "post_rst7");
    frame(1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, "d7_3c");
    pulse_ack(1);

    for (int i = 0; i < 3; i++) begin
      rd = 8'($urandom_range(0, 127));
      frame(1'b1, rd, 1'b0, 1'b1, 1'b0, $sformatf("rnd7_%0d", i));
      pulse_ack(1);
    end
    check_dut(1, "final7");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
